// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI flash port arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    READY = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  localparam int REQ_BOOT  = 0;
  localparam int REQ_CPU   = 1;
  localparam int BYTE_BITS = 8;

  // Fixed priority: the boot loader wins whenever it is requesting.
  // Returns the index of the requester to own the port (0 = boot, 1 = CPU).
  function automatic logic pick_owner(input logic [1:0] req);
    return req[REQ_BOOT] ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI byte engine: SCK divider, MSB-first transmit, receive on rising SCK,
// one-cycle done pulse with the received byte held until the next completion.
module spi_byte_shifter
  import spi_arb_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic       last,
  output logic [7:0] dout
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [7:0] rx_sr;
  logic       sck_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] dout_r;

  // Shift engine: load a byte, toggle SCK every CLKDIV cycles, sample on rise, advance on fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dout_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (load && !busy_r) begin
        busy_r  <= 1'b1;
        tx_sr   <= din;
        div_cnt <= '0;
        bit_cnt <= '0;
        sck_r   <= 1'b0;
      end else if (busy_r) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!sck_r) begin
            sck_r <= 1'b1;
            rx_sr <= {rx_sr[6:0], miso};
          end else begin
            sck_r   <= 1'b0;
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
              dout_r <= rx_sr;
            end
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

  // The final falling edge happens on this clock edge; lets the FSM return to READY
  // in the same cycle that done pulses so back-to-back starts are accepted.
  assign last = busy_r && (div_cnt == DIV_LAST) && sck_r && (bit_cnt == LAST_BIT);

  assign sck  = sck_r;
  assign mosi = tx_sr[7];
  assign busy = busy_r;
  assign done = done_r;
  assign dout = dout_r;

endmodule

// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter for the shared SPI flash port: fixed-priority ownership,
// chip-select setup/idle framing, and a mode-0 byte shifter for the owner.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLKDIV   = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] start,
  input  logic [7:0] txbyte0,
  input  logic [7:0] txbyte1,
  output logic       busy,
  output logic       done,
  output logic [7:0] rxbyte,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_csn
);

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

  arb_state_t state;
  arb_state_t next_state;
  logic       owner;
  logic [7:0] cnt;
  logic       owned;
  logic       load;
  logic       sh_last;
  logic [7:0] tx_sel;

  // State register with the owner latch and the per-state cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == SETUP) begin
        owner <= pick_owner(req);
      end
      if (next_state != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Next-state logic: arbitration, CS setup/idle timing, byte handshake.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req != 2'b00) next_state = SETUP;
      SETUP:   if (cnt == SETUP_LAST) next_state = READY;
      READY: begin
        if (!req[owner]) begin
          next_state = GAP;
        end else if (start[owner]) begin
          next_state = SHIFT;
        end
      end
      SHIFT:   if (sh_last) next_state = READY;
      GAP:     if (cnt == IDLE_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state: grant and chip select only while a requester owns the port.
  always_comb begin
    owned = (state == SETUP) || (state == READY) || (state == SHIFT);
    gnt   = 2'b00;
    if (owned) begin
      gnt = owner ? 2'b10 : 2'b01;
    end
    spi_csn = !owned;
    load    = (state == READY) && req[owner] && start[owner];
    tx_sel  = gnt[REQ_CPU] ? txbyte1 : txbyte0;
  end

  spi_byte_shifter #(
    .CLKDIV (CLKDIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (resetn),
    .load  (load),
    .din   (tx_sel),
    .miso  (spi_miso),
    .sck   (spi_sck),
    .mosi  (spi_mosi),
    .busy  (busy),
    .done  (done),
    .last  (sh_last),
    .dout  (rxbyte)
  );

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed-sequence bench for spi_flash_arbiter with randomized data bytes and a
// transaction-level slave/reference model.
module tb_spi_flash_arbiter;

  localparam int CLKDIV   = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 4;
  localparam int BYTE_LAT = 16 * CLKDIV + 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] start;
  logic [7:0] txbyte0;
  logic [7:0] txbyte1;
  logic       busy;
  logic       done;
  logic [7:0] rxbyte;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_csn;

  always #5 clk = ~clk;

  spi_flash_arbiter #(
    .CLKDIV   (CLKDIV),
    .CS_SETUP (CS_SETUP),
    .CS_IDLE  (CS_IDLE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .gnt      (gnt),
    .start    (start),
    .txbyte0  (txbyte0),
    .txbyte1  (txbyte1),
    .busy     (busy),
    .done     (done),
    .rxbyte   (rxbyte),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_csn  (spi_csn)
  );

  // Flash slave model: presents slave_resp MSB first, captures mosi on each SCK rise.
  logic [7:0] slave_resp = 8'h00;
  logic [7:0] mosi_sr    = 8'h00;
  logic [2:0] bitpos     = 3'd0;
  logic       prev_sck   = 1'b0;
  logic       prev_csn   = 1'b1;
  int         sck_rises  = 0;
  int         csn_rises  = 0;
  int         done_seen  = 0;

  assign spi_miso = slave_resp[~bitpos];

  always @(negedge clk) begin
    prev_sck <= spi_sck;
    prev_csn <= spi_csn;
    if (done) done_seen <= done_seen + 1;
    if (spi_csn) begin
      bitpos <= 3'd0;
    end else if (spi_sck && !prev_sck) begin
      bitpos    <= bitpos + 3'd1;
      mosi_sr   <= {mosi_sr[6:0], spi_mosi};
      sck_rises <= sck_rises + 1;
    end
    if (spi_csn && !prev_csn) csn_rises <= csn_rises + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference arbitration rule: boot loader over CPU.
  function automatic logic [1:0] ref_grant(input logic [1:0] r);
    if (r[0]) return 2'b01;
    if (r[1]) return 2'b10;
    return 2'b00;
  endfunction

  // Request from IDLE, expect the grant one cycle later, then wait out CS setup.
  task automatic acquire(input logic [1:0] r, input string tag);
    int lat;
    lat = 0;
    req = r;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        lat = i;
        break;
      end
    end
    check({tag, "_gnt"}, gnt, ref_grant(r));
    check({tag, "_gnt_lat"}, lat, 1);
    check({tag, "_csn_low"}, spi_csn, 1'b0);
    tick(CS_SETUP);
  endtask

  // One byte from the READY state; optionally drop req for the owner mid-byte.
  task automatic xfer(input int g, input logic [7:0] tx, input logic [7:0] resp,
                      input string tag, input int drop_at);
    int lat;
    slave_resp = resp;
    if (g == 0) begin
      txbyte0 = tx;
      txbyte1 = ~tx;
      start   = 2'b01;
    end else begin
      txbyte1 = tx;
      txbyte0 = ~tx;
      start   = 2'b10;
    end
    @(negedge clk);
    start   = 2'b00;
    txbyte0 = 8'($urandom);
    txbyte1 = 8'($urandom);
    check({tag, "_busy"}, busy, 1'b1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (drop_at != 0 && lat == drop_at) req = 2'b00;
    end
    check({tag, "_lat"}, lat, BYTE_LAT);
    check({tag, "_rx"}, rxbyte, resp);
    check({tag, "_mosi"}, mosi_sr, tx);
    check({tag, "_busy_lo"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t;
    logic [7:0] r;
    logic [7:0] b2b [4];
    int hi;
    int s0;
    int c0;
    int d0;

    b2b[0] = 8'h03;
    b2b[1] = 8'h00;
    b2b[2] = 8'h10;
    b2b[3] = 8'h00;

    resetn  = 1'b0;
    req     = 2'b00;
    start   = 2'b00;
    txbyte0 = 8'h00;
    txbyte1 = 8'h00;
    tick(3);
    check("rst_csn", spi_csn, 1'b1);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_mosi", spi_mosi, 1'b0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rxbyte, 8'h00);
    resetn = 1'b1;
    tick(2);

    // Boot loader reads one byte.
    acquire(2'b01, "t2");
    xfer(0, 8'h03, 8'hA5, "t2", 0);
    check("t2_done_csn", spi_csn, 1'b0);
    tick(1);
    check("t2_done_pulse", done, 1'b0);
    req = 2'b00;
    tick(1);
    check("t2_rel_csn", spi_csn, 1'b1);
    check("t2_rel_gnt", gnt, 2'b00);
    tick(CS_IDLE + 2);

    // Both request together: boot first, CPU after the gap.
    acquire(2'b11, "t3");
    xfer(0, 8'($urandom), 8'($urandom), "t3a", 0);
    req = 2'b10;
    tick(1);
    check("t3_rel_csn", spi_csn, 1'b1);
    check("t3_rel_gnt", gnt, 2'b00);
    hi = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) break;
      hi++;
    end
    check("t3_gnt_cpu", gnt, 2'b10);
    check("t3_gap_min", (hi >= CS_IDLE), 1'b1);
    start = 2'b10;
    @(negedge clk);
    start = 2'b00;
    check("t3_setup_drop", busy, 1'b0);
    tick(CS_SETUP - 1);
    start = 2'b01;
    @(negedge clk);
    start = 2'b00;
    check("t3_other_ignored", busy, 1'b0);
    xfer(1, 8'($urandom), 8'($urandom), "t3b", 0);
    req = 2'b00;
    tick(CS_IDLE + 3);

    // Four back-to-back bytes with start on each done cycle.
    acquire(2'b01, "t4");
    s0 = sck_rises;
    c0 = csn_rises;
    for (int k = 0; k < 4; k++) begin
      xfer(0, b2b[k], 8'($urandom), $sformatf("t4_%0d", k), 0);
    end
    tick(1);
    check("t4_sck_rises", sck_rises - s0, 32);
    check("t4_csn_glitch", csn_rises - c0, 0);
    req = 2'b00;
    tick(CS_IDLE + 3);

    // Request dropped mid-byte: byte completes, then release.
    acquire(2'b01, "t5");
    t = 8'($urandom);
    r = 8'($urandom) | 8'h01;
    xfer(0, t, r, "t5", 10);
    check("t5_done_csn", spi_csn, 1'b0);
    tick(1);
    check("t5_rel_csn", spi_csn, 1'b1);
    check("t5_rel_gnt", gnt, 2'b00);
    tick(CS_IDLE + 3);

    // Reset in the middle of a byte.
    acquire(2'b01, "t6");
    d0 = done_seen;
    slave_resp = 8'($urandom);
    txbyte0 = 8'hFF;
    start = 2'b01;
    @(negedge clk);
    start = 2'b00;
    tick(8);
    resetn = 1'b0;
    #1;
    check("t6_csn", spi_csn, 1'b1);
    check("t6_sck", spi_sck, 1'b0);
    check("t6_mosi", spi_mosi, 1'b0);
    check("t6_gnt", gnt, 2'b00);
    check("t6_busy", busy, 1'b0);
    check("t6_rx", rxbyte, 8'h00);
    req = 2'b00;
    tick(3);
    resetn = 1'b1;
    tick(BYTE_LAT);
    check("t6_no_done", done_seen - d0, 0);
    acquire(2'b01, "t6b");
    xfer(0, 8'($urandom), 8'($urandom), "t6b", 0);
    req = 2'b00;
    tick(CS_IDLE + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
